// File: rtl/led_sequencer.sv
// ============================================================================
// led_sequencer : drives WIDTH LEDs with one of four patterns, stepping on the
//                 edges of a synchronised slow tick. Option macro: LED_SEQ_BOTH_EDGES_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module led_sequencer #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [WIDTH-1:0] leds,
  output logic             step_pulse,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_FILL   = 2'b11
  } mode_t;

  localparam int               ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev_q;
  logic                   armed_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic                   evt;
  logic                   step;

  mode_t                  mode_q, mode_d, mode_in;
  logic                   dir_q, dir_d;   // 0 = moving left, 1 = moving right
  logic [WIDTH-1:0]       leds_d;
  logic                   wrap_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign mode_in = mode_t'(mode);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q <= s;
      // Stay blind until the synchroniser has flushed its reset contents.
      if (!armed_q) begin
        if (arm_cnt_q == ARM_W'(SYNC_STAGES)) armed_q   <= 1'b1;
        else                                  arm_cnt_q <= arm_cnt_q + 1'b1;
      end
    end
  end

`ifdef LED_SEQ_BOTH_EDGES_EN
  assign evt = armed_q && (s != prev_q);
`else
  assign evt = armed_q && s && !prev_q;
`endif

  assign step = evt && !hold;

  function automatic logic [WIDTH-1:0] init_of(input mode_t m);
    return ((m == MODE_WALK) || (m == MODE_BOUNCE)) ? ONE : '0;
  endfunction

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    leds_d = leds;
    wrap_d = 1'b0;
    if (step) begin
      if (mode_in != mode_q) begin
        mode_d = mode_in;
        leds_d = init_of(mode_in);
        dir_d  = 1'b0;
      end else begin
        case (mode_q)
          MODE_WALK:   leds_d = {leds[WIDTH-2:0], leds[WIDTH-1]};
          MODE_BOUNCE: begin
            if (!dir_q) begin
              leds_d = leds << 1;
              if (leds_d[WIDTH-1]) dir_d = 1'b1;
            end else begin
              leds_d = leds >> 1;
              if (leds_d[0]) dir_d = 1'b0;
            end
          end
          MODE_COUNT:  leds_d = leds + ONE;
          MODE_FILL:   leds_d = (&leds) ? '0 : {leds[WIDTH-2:0], 1'b1};
        endcase
        wrap_d = (leds_d == init_of(mode_q));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      leds       <= ONE;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      mode_q     <= MODE_WALK;
      dir_q      <= 1'b0;
    end else begin
      leds       <= leds_d;
      step_pulse <= step;
      wrap       <= wrap_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// tb_led_sequencer : directed self-checking bench for led_sequencer.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_led_sequencer;

  localparam int WIDTH = 5;
`ifdef LED_SEQ_BOTH_EDGES_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             tick_in;
  logic [1:0]       mode;
  logic             hold;
  logic [WIDTH-1:0] leds;
  logic             step_pulse;
  logic             wrap;

  int checks   = 0;
  int failures = 0;

  led_sequencer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .mode       (mode),
    .hold       (hold),
    .leds       (leds),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  always #5 clk_in = ~clk_in;

  // Flip tick_in between edges, then sample after E+1, E+2 and E+3.
  task automatic toggle_tick(output logic pre, output logic stp, output logic [WIDTH-1:0] lv,
                             output logic wv, output logic post);
    @(negedge clk_in); tick_in = ~tick_in;
    @(posedge clk_in);
    @(posedge clk_in); #1 pre = step_pulse;
    @(posedge clk_in); #1 stp = step_pulse; lv = leds; wv = wrap;
    @(posedge clk_in); #1 post = step_pulse;
  endtask

  // One applied step; in rising-only builds a falling toggle is inserted first if needed.
  task automatic do_step(output logic pre, output logic stp, output logic [WIDTH-1:0] lv,
                         output logic wv, output logic post);
    logic a, b, d, e;
    logic [WIDTH-1:0] c;
    if (!BOTH && tick_in) toggle_tick(a, b, c, d, e);
    toggle_tick(pre, stp, lv, wv, post);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0; tick_in = 1'b1; mode = 2'b00; hold = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (leds !== 5'b00001 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: leds=%b step=%b wrap=%b, required 00001/0/0", leds, step_pulse, wrap);
    end
    rst_n  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk_in); #1;
      if (step_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || leds !== 5'b00001) begin
      failures++;
      $display("FAIL reset_tick_high: pulses=%0d leds=%b, required 0/00001", pulses, leds);
    end
  endtask

  task automatic test_walk();
    logic [WIDTH-1:0] exp_l [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    logic pre, stp, wv, post;
    logic [WIDTH-1:0] lv;
    for (int i = 0; i < 5; i++) begin
      do_step(pre, stp, lv, wv, post);
      checks++;
      if (pre !== 1'b0 || stp !== 1'b1 || post !== 1'b0) begin
        failures++;
        $display("FAIL walk_timing[%0d]: pulse at E+1/E+2/E+3=%b%b%b, required 010", i, pre, stp, post);
      end
      checks++;
      if (lv !== exp_l[i] || wv !== (i == 4)) begin
        failures++;
        $display("FAIL walk[%0d]: leds=%b wrap=%b, required %b/%b", i, lv, wv, exp_l[i], (i == 4));
      end
    end
  endtask

  task automatic test_bounce();
    logic [WIDTH-1:0] exp_l [8] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                    5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic pre, stp, wv, post;
    logic [WIDTH-1:0] lv;
    mode = 2'b01;
    apply_reset();
    do_step(pre, stp, lv, wv, post);
    checks++;
    if (stp !== 1'b1 || lv !== 5'b00001 || wv !== 1'b0) begin
      failures++;
      $display("FAIL bounce_load: step=%b leds=%b wrap=%b, required 1/00001/0", stp, lv, wv);
    end
    for (int i = 0; i < 8; i++) begin
      do_step(pre, stp, lv, wv, post);
      checks++;
      if (stp !== 1'b1 || lv !== exp_l[i] || wv !== (i == 7)) begin
        failures++;
        $display("FAIL bounce[%0d]: step=%b leds=%b wrap=%b, required 1/%b/%b", i, stp, lv, wv, exp_l[i], (i == 7));
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [WIDTH-1:0] exp_f [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    logic pre, stp, wv, post;
    logic [WIDTH-1:0] lv;
    mode = 2'b10;
    apply_reset();
    repeat (4) do_step(pre, stp, lv, wv, post);
    checks++;
    if (lv !== 5'b00011) begin
      failures++;
      $display("FAIL count_prep: leds=%b, required 00011", lv);
    end
    mode = 2'b11;
    do_step(pre, stp, lv, wv, post);
    checks++;
    if (lv !== 5'b00000 || wv !== 1'b0) begin
      failures++;
      $display("FAIL fill_load: leds=%b wrap=%b, required 00000/0", lv, wv);
    end
    for (int i = 0; i < 5; i++) begin
      do_step(pre, stp, lv, wv, post);
      checks++;
      if (lv !== exp_f[i] || wv !== 1'b0) begin
        failures++;
        $display("FAIL fill[%0d]: leds=%b wrap=%b, required %b/0", i, lv, wv, exp_f[i]);
      end
    end
    do_step(pre, stp, lv, wv, post);
    checks++;
    if (lv !== 5'b00000 || wv !== 1'b1) begin
      failures++;
      $display("FAIL fill_wrap: leds=%b wrap=%b, required 00000/1", lv, wv);
    end
  endtask

  task automatic test_hold();
    logic pre, stp, wv, post;
    logic [WIDTH-1:0] lv;
    mode = 2'b10;
    apply_reset();
    repeat (5) do_step(pre, stp, lv, wv, post);
    checks++;
    if (lv !== 5'b00100) begin
      failures++;
      $display("FAIL hold_prep: leds=%b, required 00100", lv);
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      toggle_tick(pre, stp, lv, wv, post);
      checks++;
      if ((pre | stp | post) !== 1'b0 || lv !== 5'b00100) begin
        failures++;
        $display("FAIL hold[%0d]: pulse=%b%b%b leds=%b, required 000/00100", i, pre, stp, post, lv);
      end
    end
    hold = 1'b0;
    do_step(pre, stp, lv, wv, post);
    checks++;
    if (stp !== 1'b1 || lv !== 5'b00101) begin
      failures++;
      $display("FAIL hold_release: step=%b leds=%b, required 1/00101", stp, lv);
    end
  endtask

  task automatic test_async_reset();
    logic a, b, d, e;
    logic [WIDTH-1:0] c;
    if (!BOTH && tick_in) toggle_tick(a, b, c, d, e);
    @(negedge clk_in); tick_in = ~tick_in;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (step_pulse !== 1'b1 || leds !== 5'b00110) begin
      failures++;
      $display("FAIL async_prep: step=%b leds=%b, required 1/00110", step_pulse, leds);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (leds !== 5'b00001 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: leds=%b step=%b wrap=%b, required 00001/0/0", leds, step_pulse, wrap);
    end
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_edge_config();
    logic pre, stp, wv, post;
    logic [WIDTH-1:0] lv;
    int steps;
    mode = 2'b00;
    apply_reset();
    steps = 0;
    for (int i = 0; i < 4; i++) begin
      toggle_tick(pre, stp, lv, wv, post);
      if (stp === 1'b1) steps++;
    end
    checks++;
    if (steps != (BOTH ? 4 : 2) || lv !== (BOTH ? 5'b10000 : 5'b00100)) begin
      failures++;
      $display("FAIL edge_config: steps=%0d leds=%b, required %0d/%b",
               steps, lv, (BOTH ? 4 : 2), (BOTH ? 5'b10000 : 5'b00100));
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bounce();
    test_mode_switch();
    test_hold();
    test_async_reset();
    test_edge_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
